// File: rtl/i2cmb_seq_pkg.sv
// Shared types and constants for the I2CMB Wishbone sequencer:
// core register map, command codes, status/state encodings.
package i2cmb_seq_pkg;
    typedef enum logic [1:0] {
        REG_CSR  = 2'd0,
        REG_DPR  = 2'd1,
        REG_CMDR = 2'd2,
        REG_FSMR = 2'd3
    } wb_reg_e;

    localparam logic [7:0] CMD_WRITE    = 8'h01;
    localparam logic [7:0] CMD_READ_ACK = 8'h02;
    localparam logic [7:0] CMD_READ_NAK = 8'h03;
    localparam logic [7:0] CMD_START    = 8'h04;
    localparam logic [7:0] CMD_STOP     = 8'h05;
    localparam logic [7:0] CMD_SET_BUS  = 8'h06;
    localparam logic [7:0] CSR_ENABLE   = 8'hC0;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_NAK      = 2'd1,
        ST_ARB_LOST = 2'd2,
        ST_ERR      = 2'd3
    } status_e;

    typedef enum logic [3:0] {
        S_IDLE, S_ENABLE, S_SET_BUS, S_START, S_ADDR,
        S_DATA, S_RDPR, S_STOP, S_DONE
    } state_e;

    localparam int BIT_DON = 7;
    localparam int BIT_NAK = 6;
    localparam int BIT_AL  = 5;
    localparam int BIT_ERR = 4;
endpackage

// File: rtl/i2cmb_wb_xfer.sv
// Single Wishbone access: bus signals held until ack, done pulses the cycle after,
// and cyc/stb drop on ack so back-to-back accesses always see an idle cycle.
module i2cmb_wb_xfer #(
    parameter int WB_ADDR_WIDTH = 2,
    parameter int WB_DATA_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     go_i,
    input  logic                     we_i,
    input  logic [WB_ADDR_WIDTH-1:0] adr_i,
    input  logic [WB_DATA_WIDTH-1:0] wdata_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [WB_DATA_WIDTH-1:0] rdata_o,
    output logic                     cyc_o,
    output logic                     stb_o,
    output logic                     we_o,
    output logic [WB_ADDR_WIDTH-1:0] adr_o,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    input  logic                     ack_i
);
    assign busy_o = cyc_o;

    always_ff @(posedge clk_i) begin
        done_o <= 1'b0;
        if (rst_i) begin
            cyc_o   <= 1'b0;
            stb_o   <= 1'b0;
            we_o    <= 1'b0;
            adr_o   <= '0;
            dat_o   <= '0;
            rdata_o <= '0;
        end else if (cyc_o) begin
            if (ack_i) begin
                cyc_o   <= 1'b0;
                stb_o   <= 1'b0;
                rdata_o <= dat_i;
                done_o  <= 1'b1;
            end
        end else if (go_i) begin
            cyc_o <= 1'b1;
            stb_o <= 1'b1;
            we_o  <= we_i;
            adr_o <= adr_i;
            dat_o <= wdata_i;
        end
    end
endmodule

// File: rtl/i2cmb_wb_sequencer.sv
// Turns byte-stream I2C transaction requests into the register-level
// command sequence of an I2CMB core over a Wishbone master port.
import i2cmb_seq_pkg::*;

module i2cmb_wb_sequencer #(
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter int I2C_ADDR_WIDTH = 7
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [3:0]                req_bus_i,
    input  logic [I2C_ADDR_WIDTH-1:0] req_addr_i,
    input  logic                      req_op_i,
    input  logic [5:0]                req_len_i,
    input  logic                      wdata_valid_i,
    input  logic [7:0]                wdata_i,
    output logic                      wdata_ready_o,
    output logic                      rdata_valid_o,
    output logic [7:0]                rdata_o,
    output logic                      done_o,
    output logic [1:0]                status_o,
    output logic                      cyc_o,
    output logic                      stb_o,
    output logic                      we_o,
    output logic [WB_ADDR_WIDTH-1:0]  adr_o,
    output logic [WB_DATA_WIDTH-1:0]  dat_o,
    input  logic [WB_DATA_WIDTH-1:0]  dat_i,
    input  logic                      ack_i,
    input  logic                      irq_i
);
    state_e                    r_state;
    status_e                   r_status;
    logic [2:0]                r_sub;
    logic                      r_wait, r_go, r_we;
    logic [WB_ADDR_WIDTH-1:0]  r_adr;
    logic [WB_DATA_WIDTH-1:0]  r_wdat, r_rd;
    logic                      r_en_done, r_bus_vld;
    logic [3:0]                r_bus_id, r_req_bus;
    logic [I2C_ADDR_WIDTH-1:0] r_req_addr;
    logic                      r_req_op;
    logic [5:0]                r_len, r_cnt;
    logic                      w_busy, w_done, w_stat_err;
    logic [WB_DATA_WIDTH-1:0]  w_rdata;
    logic [7:0]                w_cmd;

    i2cmb_wb_xfer #(.WB_ADDR_WIDTH(WB_ADDR_WIDTH), .WB_DATA_WIDTH(WB_DATA_WIDTH)) u_xfer (
        .clk_i(clk_i), .rst_i(rst_i), .go_i(r_go), .we_i(r_we), .adr_i(r_adr),
        .wdata_i(r_wdat), .busy_o(w_busy), .done_o(w_done), .rdata_o(w_rdata),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .dat_i(dat_i), .ack_i(ack_i)
    );

    assign req_ready_o = (r_state == S_IDLE);
    // A status read with no completion bit at all is treated as a core error.
    assign w_stat_err  = r_rd[BIT_ERR] | ~(r_rd[BIT_DON] | r_rd[BIT_NAK] | r_rd[BIT_AL]);

    always_comb begin
        w_cmd = 8'h00;
        case (r_state)
            S_SET_BUS: w_cmd = CMD_SET_BUS;
            S_START:   w_cmd = CMD_START;
            S_ADDR:    w_cmd = CMD_WRITE;
            S_DATA:    w_cmd = !r_req_op ? CMD_WRITE :
                               (r_cnt == r_len - 6'd1) ? CMD_READ_NAK : CMD_READ_ACK;
            S_STOP:    w_cmd = CMD_STOP;
            default:   w_cmd = 8'h00;
        endcase
    end

    task wb_issue(input logic we, input wb_reg_e adr, input logic [WB_DATA_WIDTH-1:0] dat);
        r_go   <= 1'b1;
        r_we   <= we;
        r_adr  <= WB_ADDR_WIDTH'(adr);
        r_wdat <= dat;
        r_wait <= 1'b1;
    endtask

    // Each command state walks r_sub: 0 DPR pre-write, 1 CMDR write, 2 irq wait,
    // 3 CMDR read, 4 status decision. r_wait parks the walk during an access.
    always_ff @(posedge clk_i) begin
        r_go          <= 1'b0;
        wdata_ready_o <= 1'b0;
        rdata_valid_o <= 1'b0;
        done_o        <= 1'b0;
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_status  <= ST_OK;
            r_sub     <= '0;
            r_wait    <= 1'b0;
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_wdat    <= '0;
            r_rd      <= '0;
            r_en_done <= 1'b0;
            r_bus_vld <= 1'b0;
            r_bus_id  <= '0;
            r_cnt     <= '0;
            rdata_o   <= '0;
            status_o  <= '0;
        end else if (r_wait) begin
            if (w_done) begin
                r_wait <= 1'b0;
                r_rd   <= w_rdata;
                r_sub  <= r_sub + 3'd1;
            end
        end else begin
            case (r_state)
                S_IDLE: if (req_valid_i) begin
                    r_req_bus  <= req_bus_i;
                    r_req_addr <= req_addr_i;
                    r_req_op   <= req_op_i;
                    r_len      <= req_len_i;
                    r_cnt      <= '0;
                    r_sub      <= '0;
                    r_status   <= ST_OK;
                    r_state    <= !r_en_done ? S_ENABLE :
                                  (r_bus_vld && r_bus_id == req_bus_i) ? S_START : S_SET_BUS;
                end
                S_ENABLE: if (r_sub == 3'd0) wb_issue(1'b1, REG_CSR, WB_DATA_WIDTH'(CSR_ENABLE));
                else begin
                    r_en_done <= 1'b1;
                    r_sub     <= '0;
                    r_state   <= (r_bus_vld && r_bus_id == r_req_bus) ? S_START : S_SET_BUS;
                end
                S_RDPR: if (r_sub == 3'd0) wb_issue(1'b0, REG_DPR, '0);
                else begin
                    rdata_valid_o <= 1'b1;
                    rdata_o       <= r_rd[7:0];
                    r_cnt         <= r_cnt + 6'd1;
                    r_sub         <= '0;
                    r_state       <= (r_cnt + 6'd1 == r_len) ? S_STOP : S_DATA;
                end
                S_DONE: begin
                    done_o   <= 1'b1;
                    status_o <= r_status;
                    r_state  <= S_IDLE;
                end
                default: case (r_sub)
                    3'd0: begin
                        if (r_state == S_SET_BUS)
                            wb_issue(1'b1, REG_DPR, WB_DATA_WIDTH'(r_req_bus));
                        else if (r_state == S_ADDR)
                            wb_issue(1'b1, REG_DPR, WB_DATA_WIDTH'({r_req_addr, r_req_op}));
                        else if (r_state == S_DATA && !r_req_op) begin
                            if (wdata_valid_i) begin
                                wdata_ready_o <= 1'b1;
                                wb_issue(1'b1, REG_DPR, WB_DATA_WIDTH'(wdata_i));
                            end
                        end else
                            r_sub <= 3'd1;
                    end
                    3'd1: wb_issue(1'b1, REG_CMDR, WB_DATA_WIDTH'(w_cmd));
                    3'd2: if (irq_i && !w_busy) r_sub <= 3'd3;
                    3'd3: wb_issue(1'b0, REG_CMDR, '0);
                    default: begin
                        r_sub <= '0;
                        if (w_stat_err) begin
                            r_status  <= ST_ERR;
                            r_bus_vld <= 1'b0;
                            r_state   <= S_DONE;
                        end else if (r_rd[BIT_AL]) begin
                            r_status  <= ST_ARB_LOST;
                            r_bus_vld <= 1'b0;
                            r_state   <= S_DONE;
                        end else if (r_rd[BIT_NAK] && r_state != S_STOP) begin
                            r_status <= ST_NAK;
                            r_state  <= S_STOP;
                        end else case (r_state)
                            S_SET_BUS: begin
                                r_bus_vld <= 1'b1;
                                r_bus_id  <= r_req_bus;
                                r_state   <= S_START;
                            end
                            S_START: r_state <= S_ADDR;
                            S_ADDR:  r_state <= (r_len == 6'd0) ? S_STOP : S_DATA;
                            S_DATA: if (r_req_op) r_state <= S_RDPR;
                            else begin
                                r_cnt   <= r_cnt + 6'd1;
                                r_state <= (r_cnt + 6'd1 == r_len) ? S_STOP : S_DATA;
                            end
                            default: r_state <= S_DONE;
                        endcase
                    end
                endcase
            endcase
        end
    end
endmodule

// File: tb/tb_i2cmb_wb_sequencer.sv
// Directed bench: a behavioural I2CMB register model answers the Wishbone port,
// every access is logged and compared against hand-built expected sequences.
module tb_i2cmb_wb_sequencer;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       req_valid_i = 1'b0;
    logic       req_ready_o;
    logic [3:0] req_bus_i = '0;
    logic [6:0] req_addr_i = '0;
    logic       req_op_i = 1'b0;
    logic [5:0] req_len_i = '0;
    logic       wdata_valid_i = 1'b0;
    logic [7:0] wdata_i = '0;
    logic       wdata_ready_o, rdata_valid_o, done_o;
    logic [7:0] rdata_o;
    logic [1:0] status_o;
    logic       cyc_o, stb_o, we_o;
    logic [1:0] adr_o;
    logic [7:0] dat_o;
    logic [7:0] dat_i = '0;
    logic       ack_i = 1'b0;
    logic       irq_i = 1'b0;

    i2cmb_wb_sequencer dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_bus_i(req_bus_i), .req_addr_i(req_addr_i), .req_op_i(req_op_i),
        .req_len_i(req_len_i), .wdata_valid_i(wdata_valid_i), .wdata_i(wdata_i),
        .wdata_ready_o(wdata_ready_o), .rdata_valid_o(rdata_valid_o), .rdata_o(rdata_o),
        .done_o(done_o), .status_o(status_o), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
        .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i)
    );

    always #5 clk_i = ~clk_i;

    int          total = 0, bad = 0;
    logic [10:0] acc_log[$], eq[$];
    logic [7:0]  rq[$], wq[$];
    int          done_cnt = 0, dprev = 0, wr_taken = 0;
    logic [1:0]  last_status = '0;
    bit          wv_en = 1'b1, nak_en = 1'b0, in_addr = 1'b0;
    logic [6:0]  nak_addr = '0;
    logic [7:0]  last_dpr = '0, stat = 8'h80, force_start = 8'h00;
    int          al_byte = -1, dcnt = 0, rd_val = 0, rd_step = 1;

    // Register-level model of the core, driven on the falling edge.
    always @(negedge clk_i) begin
        if (rst_i) begin
            ack_i = 1'b0; irq_i = 1'b0; in_addr = 1'b0;
        end else if (ack_i) ack_i = 1'b0;
        else if (cyc_o && stb_o) begin
            ack_i = 1'b1;
            acc_log.push_back({we_o, adr_o, we_o ? dat_o : 8'h00});
            dat_i = 8'h00;
            if (we_o) begin
                if (adr_o == 2'd1) last_dpr = dat_o;
                if (adr_o == 2'd2) begin
                    stat = 8'h80;
                    if (dat_o == 8'h04) begin
                        in_addr = 1'b1; dcnt = 0;
                        if (force_start != 8'h00) stat = force_start;
                    end else if (dat_o == 8'h01 && in_addr) begin
                        in_addr = 1'b0;
                        if (nak_en && last_dpr[7:1] == nak_addr) stat = 8'hC0;
                    end else if (dat_o >= 8'h01 && dat_o <= 8'h03) begin
                        if (dcnt == al_byte) stat = 8'hA0;
                        dcnt++;
                    end
                    irq_i = 1'b1;
                end
            end else if (adr_o == 2'd2) begin
                dat_i = stat; irq_i = 1'b0;
            end else if (adr_o == 2'd1) begin
                dat_i = rd_val[7:0]; rd_val = rd_val + rd_step;
            end
        end
        if (done_o) begin done_cnt++; last_status = status_o; end
        if (rdata_valid_o) rq.push_back(rdata_o);
        if (wdata_ready_o && wq.size() > 0) begin void'(wq.pop_front()); wr_taken++; end
        wdata_i = (wq.size() > 0) ? wq[0] : 8'h00;
        wdata_valid_i = wv_en && (wq.size() > 0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic ex_w(input logic [1:0] a, input logic [7:0] d); eq.push_back({1'b1, a, d}); endtask
    task automatic ex_r(input logic [1:0] a); eq.push_back({1'b0, a, 8'h00}); endtask
    task automatic ex_cmd(input logic [7:0] c); ex_w(2'd2, c); ex_r(2'd2); endtask

    task automatic chk_log(input string tag);
        chk({tag, ".nacc"}, acc_log.size(), eq.size());
        for (int i = 0; i < eq.size() && i < acc_log.size(); i++) begin
            chk($sformatf("%s.acc%0d", tag, i), acc_log[i], eq[i]);
            if (acc_log[i] !== eq[i]) break;
        end
        acc_log.delete(); eq.delete();
    endtask

    task automatic start_req(input logic [3:0] b, input logic [6:0] a, input logic op, input logic [5:0] len);
        @(negedge clk_i);
        dprev = done_cnt;
        req_bus_i = b; req_addr_i = a; req_op_i = op; req_len_i = len; req_valid_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic [1:0] exp_st);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk_i); #1;
            if (done_cnt != dprev) begin got = 1'b1; break; end
        end
        chk({tag, ".done"}, 32'(got), 32'd1);
        chk({tag, ".status"}, 32'(last_status), 32'(exp_st));
        repeat (2) @(posedge clk_i);
        #1 chk({tag, ".npulse"}, done_cnt - dprev, 32'd1);
    endtask

    task automatic run(input string tag, input logic [3:0] b, input logic [6:0] a, input logic op,
                       input logic [5:0] len, input logic [1:0] exp_st);
        start_req(b, a, op, len);
        wait_done(tag, exp_st);
        chk_log(tag);
    endtask

    initial begin
        int wr0, prev;
        bit hit;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst.cyc", cyc_o, 0);        chk("rst.stb", stb_o, 0);
        chk("rst.we", we_o, 0);          chk("rst.adr", adr_o, 0);
        chk("rst.dat", dat_o, 0);        chk("rst.wrdy", wdata_ready_o, 0);
        chk("rst.rvld", rdata_valid_o, 0); chk("rst.rdata", rdata_o, 0);
        chk("rst.done", done_o, 0);      chk("rst.status", status_o, 0);
        chk("rst.ready", req_ready_o, 1);
        @(negedge clk_i) rst_i = 1'b0;

        // 32-byte write after reset: enable, set bus, full byte stream.
        for (int i = 0; i < 32; i++) wq.push_back(8'(i));
        ex_w(2'd0, 8'hC0); ex_w(2'd1, 8'h05); ex_cmd(8'h06); ex_cmd(8'h04);
        ex_w(2'd1, 8'h44); ex_cmd(8'h01);
        for (int i = 0; i < 32; i++) begin ex_w(2'd1, 8'(i)); ex_cmd(8'h01); end
        ex_cmd(8'h05);
        run("wr32", 4'd5, 7'h22, 1'b0, 6'd32, 2'd0);
        chk("wr32.consumed", wq.size(), 0);

        // 32-byte read on the same bus, with a request pulsed while busy.
        rd_val = 100; rd_step = 1;
        ex_cmd(8'h04); ex_w(2'd1, 8'h45); ex_cmd(8'h01);
        for (int i = 0; i < 32; i++) begin ex_cmd(i == 31 ? 8'h03 : 8'h02); ex_r(2'd1); end
        ex_cmd(8'h05);
        start_req(4'd5, 7'h22, 1'b1, 6'd32);
        repeat (20) @(negedge clk_i);
        req_bus_i = 4'd9; req_addr_i = 7'h11; req_op_i = 1'b0; req_len_i = 6'd3; req_valid_i = 1'b1;
        repeat (5) @(negedge clk_i);
        req_valid_i = 1'b0;
        wait_done("rd32", 2'd0);
        chk_log("rd32");
        chk("rd32.nbytes", rq.size(), 32);
        for (int i = 0; i < 32 && i < rq.size(); i++) chk($sformatf("rd32.b%0d", i), rq[i], 100 + i);
        rq.delete();
        repeat (40) @(posedge clk_i);
        #1 chk("busyreq.ignored", acc_log.size(), 0);
        chk("busyreq.ready", req_ready_o, 1);

        // Alternating single-byte write/read.
        rd_val = 63; rd_step = -1;
        for (int i = 0; i < 64; i++) begin
            wq.push_back(8'(64 + i));
            ex_cmd(8'h04); ex_w(2'd1, 8'h44); ex_cmd(8'h01); ex_w(2'd1, 8'(64 + i)); ex_cmd(8'h01); ex_cmd(8'h05);
            run($sformatf("alt_w%0d", i), 4'd5, 7'h22, 1'b0, 6'd1, 2'd0);
            ex_cmd(8'h04); ex_w(2'd1, 8'h45); ex_cmd(8'h01); ex_cmd(8'h03); ex_r(2'd1); ex_cmd(8'h05);
            run($sformatf("alt_r%0d", i), 4'd5, 7'h22, 1'b1, 6'd1, 2'd0);
            chk($sformatf("alt_r%0d.data", i), (rq.size() == 1) ? rq[0] : 8'hXX, 8'(63 - i));
            rq.delete();
        end

        // Address NAK: stop issued, no data moved; then a plain ACKed probe.
        nak_en = 1'b1; nak_addr = 7'h30;
        for (int i = 0; i < 4; i++) wq.push_back(8'hE0 + 8'(i));
        ex_cmd(8'h04); ex_w(2'd1, 8'h60); ex_cmd(8'h01); ex_cmd(8'h05);
        run("nak", 4'd5, 7'h30, 1'b0, 6'd4, 2'd1);
        chk("nak.untouched", wq.size(), 4);
        wq.delete(); nak_en = 1'b0;
        ex_cmd(8'h04); ex_w(2'd1, 8'h60); ex_cmd(8'h01); ex_cmd(8'h05);
        run("probe", 4'd5, 7'h30, 1'b0, 6'd0, 2'd0);

        // Write stream stall: no bus activity while no byte is offered.
        wv_en = 1'b0;
        wq.push_back(8'hAA); wq.push_back(8'hBB);
        start_req(4'd5, 7'h22, 1'b0, 6'd2);
        repeat (150) @(negedge clk_i);
        @(posedge clk_i); #1;
        chk("stall.cyc", cyc_o, 0);
        chk("stall.nacc", acc_log.size(), 5);
        wv_en = 1'b1;
        wait_done("stall", 2'd0);
        ex_cmd(8'h04); ex_w(2'd1, 8'h44); ex_cmd(8'h01);
        ex_w(2'd1, 8'hAA); ex_cmd(8'h01); ex_w(2'd1, 8'hBB); ex_cmd(8'h01); ex_cmd(8'h05);
        chk_log("stall");

        // Arbitration lost at data byte 3: no stop, bus cache dropped.
        al_byte = 3;
        for (int i = 0; i < 8; i++) wq.push_back(8'h10 + 8'(i));
        ex_cmd(8'h04); ex_w(2'd1, 8'h44); ex_cmd(8'h01);
        for (int i = 0; i < 4; i++) begin ex_w(2'd1, 8'h10 + 8'(i)); ex_cmd(8'h01); end
        run("al", 4'd5, 7'h22, 1'b0, 6'd8, 2'd2);
        al_byte = -1; wq.delete();
        ex_w(2'd1, 8'h05); ex_cmd(8'h06); ex_cmd(8'h04); ex_w(2'd1, 8'h44); ex_cmd(8'h01); ex_cmd(8'h05);
        run("al_rebus", 4'd5, 7'h22, 1'b0, 6'd0, 2'd0);

        // All error bits at once: ERR wins; then AL wins over NAK.
        force_start = 8'hF0;
        ex_cmd(8'h04);
        run("err", 4'd5, 7'h22, 1'b0, 6'd0, 2'd3);
        force_start = 8'h00;
        ex_w(2'd1, 8'h05); ex_cmd(8'h06); ex_cmd(8'h04); ex_w(2'd1, 8'h44); ex_cmd(8'h01); ex_cmd(8'h05);
        run("err_rebus", 4'd5, 7'h22, 1'b0, 6'd0, 2'd0);
        force_start = 8'hE0;
        ex_cmd(8'h04);
        run("al_nak", 4'd5, 7'h22, 1'b0, 6'd0, 2'd2);
        force_start = 8'h00;

        // Reset during byte 10 of a write.
        for (int i = 0; i < 32; i++) wq.push_back(8'(i));
        wr0 = wr_taken; hit = 1'b0;
        start_req(4'd5, 7'h22, 1'b0, 6'd32);
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk_i); #1;
            if (wr_taken - wr0 >= 11) begin hit = 1'b1; break; end
        end
        chk("mrst.reach", 32'(hit), 32'd1);
        prev = done_cnt;
        @(negedge clk_i) rst_i = 1'b1;
        @(posedge clk_i); #1;
        chk("mrst.cyc", cyc_o, 0);
        chk("mrst.stb", stb_o, 0);
        @(negedge clk_i) rst_i = 1'b0;
        wq.delete();
        repeat (30) @(posedge clk_i);
        #1 chk("mrst.nodone", done_cnt, prev);
        chk("mrst.ready", req_ready_o, 1);
        acc_log.delete();
        ex_w(2'd0, 8'hC0); ex_w(2'd1, 8'h05); ex_cmd(8'h06); ex_cmd(8'h04);
        ex_w(2'd1, 8'h44); ex_cmd(8'h01); ex_cmd(8'h05);
        run("mrst_reen", 4'd5, 7'h22, 1'b0, 6'd0, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i2cmb_wb_sequencer.md
I2CMB_WB_SEQUENCER -- requirements
Module: i2cmb_wb_sequencer

Interface
REQ-001 SHALL have parameter WB_ADDR_WIDTH, default 2, Wishbone register address width.
REQ-002 SHALL have parameter WB_DATA_WIDTH, default 8, Wishbone data width.
REQ-003 SHALL have parameter I2C_ADDR_WIDTH, default 7, I2C slave address width.
REQ-004 SHALL have one clock and a synchronous, active-high reset, as the following two ports.
REQ-005 clk_i  in  1  system clock; all logic on rising edge.
REQ-006 rst_i  in  1  reset; synchronous, active-high.
REQ-007 req_valid_i  in  1  transaction request valid.
REQ-008 req_ready_o  out  1  sequencer idle, accepts request.
REQ-009 req_bus_i  in  4  target I2C bus ID.
REQ-010 req_addr_i  in  I2C_ADDR_WIDTH  slave address.
REQ-011 req_op_i  in  1  0 = write, 1 = read.
REQ-012 req_len_i  in  6  byte count, 0..32.
REQ-013 wdata_valid_i / wdata_i  in  1 / 8  write-byte stream.
REQ-014 wdata_ready_o  out  1  write byte consumed this cycle.
REQ-015 rdata_valid_o / rdata_o  out  1 / 8  read-byte stream; no backpressure.
REQ-016 done_o / status_o  out  1 / 2  completion pulse; status 0 = OK, 1 = NAK, 2 = ARB_LOST, 3 = ERR.
REQ-017 cyc_o, stb_o, we_o  out  1 each  Wishbone master controls.
REQ-018 adr_o / dat_o  out  WB_ADDR_WIDTH / WB_DATA_WIDTH  register address / write data.
REQ-019 dat_i / ack_i  in  WB_DATA_WIDTH / 1  read data / acknowledge.
REQ-020 irq_i  in  1  core interrupt request.

Function
REQ-021 Each Wishbone access SHALL hold cyc_o, stb_o, adr_o, dat_o and we_o stable until the first ack_i cycle, then deassert cyc_o and stb_o for at least one cycle; dat_i SHALL be sampled on ack_i.
REQ-022 Every CMDR command SHALL be followed by waiting for irq_i = 1 and then a CMDR read; status bits are DON = 7, NAK = 6, AL = 5, ERR = 4.
REQ-023 The state machine SHALL have states IDLE, ENABLE, SET_BUS, START, ADDR, DATA, RDPR, STOP and DONE.
REQ-024 The first request after reset SHALL pass through ENABLE: CSR write of 0xC0 (core enable + interrupt enable), issued once per reset.
REQ-025 In SET_BUS, DPR SHALL be written with req_bus_i, then CMDR = 0x06; this SHALL be skipped when the bus ID equals the last successfully set ID.
REQ-026 START SHALL write CMDR = 0x04.
REQ-027 ADDR SHALL write DPR = {addr, op}, then CMDR = 0x01.
REQ-028 Write bytes: per byte, the sequencer SHALL stall with cyc_o = 0 while wdata_valid_i = 0, pulse wdata_ready_o for 1 cycle when a byte is taken, write DPR with it, then write CMDR = 0x01.
REQ-029 Read bytes: CMDR = 0x02 for bytes 0..len-2 and 0x03 for the last byte; then RDPR SHALL read DPR and pulse rdata_valid_o for 1 cycle with that value.
REQ-030 STOP SHALL write CMDR = 0x05; DONE SHALL pulse done_o for 1 cycle with status_o valid in that cycle, then return to IDLE.
REQ-031 req_ready_o SHALL be 1 only in IDLE; request fields SHALL be latched on req_valid_i & req_ready_o.
REQ-032 req_len_i = 0 SHALL give START, ADDR, STOP (address probe); status is OK if ACKed, else NAK.
REQ-033 NAK on address or data SHALL go to STOP, then DONE with status NAK; the remaining bytes are not transferred.
REQ-034 AL SHALL go directly to DONE with ARB_LOST (no STOP) and invalidate the cached bus ID.
REQ-035 ERR SHALL go directly to DONE with ERR and invalidate the cached bus ID.
REQ-036 If NAK, AL and ERR are set together, priority SHALL be ERR > AL > NAK.
REQ-037 A new req_valid_i while busy SHALL be ignored (not latched).

Reset
REQ-038 While rst_i = 1, the following SHALL be forced at the clock edge: state = IDLE, and cyc_o, stb_o, we_o, adr_o, dat_o, wdata_ready_o, rdata_valid_o, rdata_o, done_o and status_o all = 0.
REQ-039 Assertion of rst_i mid-operation SHALL abort the transaction without issuing done_o.
REQ-040 Reset SHALL clear the enable-done flag and the cached bus ID.

Structure
REQ-041 Package i2cmb_seq_pkg SHALL hold: the register enum (CSR = 0, DPR = 1, CMDR = 2, FSMR = 3); command constants (0x01 WRITE, 0x02 READ_ACK, 0x03 READ_NAK, 0x04 START, 0x05 STOP, 0x06 SET_BUS); the status enum; the state enum; and the status bit positions.
REQ-042 Sub-module i2cmb_wb_xfer SHALL implement the single-access Wishbone handshake (go/we/adr/wdata in; busy/done/rdata out).

Verification
REQ-043 Scenario: reset, then write request bus 5, addr 0x22, len 32, data 0..31 -> Wishbone sequence CSR 0xC0, DPR 5, CMDR 6, CMDR 4, DPR 0x44, CMDR 1, 32× (DPR i, CMDR 1), CMDR 5; done_o with OK.
REQ-044 Scenario: read addr 0x22, len 32, slave returns 100..131 -> DPR 0x45; CMDR 2 ×31 then CMDR 3; rdata_o = 100..131 in order; no SET_BUS (same bus); OK.
REQ-045 Scenario: 64 alternating write len 1 (64+i) / read len 1 -> every read uses CMDR 3; rdata_o = 63 down to 0.
REQ-046 Scenario: slave NAKs address 0x30 -> CMDR 5 issued, no data accesses, status NAK; len 0 probe with ACK -> OK.
REQ-047 Scenario: force AL in CMDR read during byte 3 -> no STOP, status ARB_LOST, next request re-issues SET_BUS.
REQ-048 Scenario: rst_i pulsed during byte 10 of a write -> cyc_o = 0 next cycle, no done_o, next request re-issues CSR 0xC0.
